// File: rtl/move_cmd_sequencer_pkg.sv
// Shared definitions for the move command sequencer: direction codes, FSM
// state encodings and the fixed-priority press arbiter.
package move_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  // Press vector bit order: [0]=up [1]=down [2]=left [3]=right.
  function automatic dir_t arb_dir(input logic [3:0] press);
    if (press[0])      return DIR_UP;
    else if (press[1]) return DIR_DOWN;
    else if (press[2]) return DIR_LEFT;
    else if (press[3]) return DIR_RIGHT;
    else               return DIR_NONE;
  endfunction

  function automatic logic multi_press(input logic [3:0] press);
    return (press & (press - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/move_cmd_sequencer_if.sv
// Command bus between the move sequencer (master) and the board engine (slave).
interface move_cmd_sequencer_if;
  // Handshake: a command transfers on a clock edge where O_move_valid and
  // I_move_ready are both high. Once raised, O_move_valid and O_move_dir stay
  // unchanged until that edge; the sole exception is game-over, which may
  // withdraw the offer. I_move_done is a one-cycle pulse after the move ends.
  logic       O_move_valid;
  logic [2:0] O_move_dir;
  logic       I_move_ready;
  logic       I_move_done;

  modport master (output O_move_valid, output O_move_dir,
                  input  I_move_ready, input  I_move_done);
  modport slave  (input  O_move_valid, input  O_move_dir,
                  output I_move_ready, output I_move_done);
endinterface

// File: rtl/move_cmd_sequencer_button_debounce.sv
// One push button: 2-flop synchroniser, stability counter and rising-edge
// press pulse derived from the debounced level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_raw,
  output logic O_level,
  output logic O_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d, stable_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips only when the counter already sits at its last value and
  // the synced input still disagrees, so a change needs DEBOUNCE_CYCLES
  // consecutive disagreeing cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync2_q;
      else                   cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= I_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign O_level = stable_q;
  assign O_press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/move_cmd_sequencer.sv
// Turns four raw direction buttons into single move commands: debounce,
// priority arbitration, one-deep pending slot, handshake FSM and move counter.
module move_cmd_sequencer
  import move_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_up,
  input  logic                  I_down,
  input  logic                  I_left,
  input  logic                  I_right,
  input  logic                  I_gameover,
  input  logic                  I_restart,
  move_cmd_sequencer_if.master  move_bus,
  output logic [CNT_W-1:0]      O_move_count,
  output logic                  O_busy,
  output logic                  O_drop,
  output logic                  O_locked,
  output state_t                O_dbg_state,
  output logic [3:0]            O_dbg_level
);

  logic [3:0] raw, press;
  assign raw = {I_right, I_left, I_down, I_up};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .I_clk   (I_clk),
      .I_rst   (I_rst),
      .I_raw   (raw[g]),
      .O_level (O_dbg_level[g]),
      .O_press (press[g])
    );
  end

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  dir_t             pend_dir_q, pend_dir_d;
  logic             pend_full_q, pend_full_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;

  dir_t win;
  logic any_press, multi, accept;

  assign win       = arb_dir(press);
  assign any_press = |press;
  assign multi     = multi_press(press);
  assign accept    = (state_q == ST_ISSUE) && move_bus.I_move_ready && !I_gameover;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    pend_dir_d  = pend_dir_q;
    pend_full_d = pend_full_q;
    drop_d      = 1'b0;
    count_d     = count_q;

    if (I_restart)   count_d = '0;
    else if (accept) count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    if (I_gameover) begin
      state_d     = ST_LOCK;
      pend_full_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_press) begin
            state_d = ST_ISSUE;
            dir_d   = win;
            drop_d  = multi;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (state_q == ST_WAIT && move_bus.I_move_done) begin
            // A finished move frees the slot first, so a same-cycle press
            // either issues directly or refills the just-emptied slot.
            if (pend_full_q) begin
              state_d     = ST_ISSUE;
              dir_d       = pend_dir_q;
              pend_full_d = any_press;
              pend_dir_d  = any_press ? win : pend_dir_q;
              drop_d      = multi;
            end else if (any_press) begin
              state_d = ST_ISSUE;
              dir_d   = win;
              drop_d  = multi;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            if (state_q == ST_ISSUE && move_bus.I_move_ready) state_d = ST_WAIT;
            if (any_press) begin
              if (!pend_full_q) begin
                pend_full_d = 1'b1;
                pend_dir_d  = win;
                drop_d      = multi;
              end else begin
                drop_d = 1'b1;
              end
            end
          end
        end
        ST_LOCK: begin
          if (I_restart) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_NONE;
      pend_dir_q  <= DIR_NONE;
      pend_full_q <= 1'b0;
      drop_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pend_dir_q  <= pend_dir_d;
      pend_full_q <= pend_full_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
    end
  end

  assign move_bus.O_move_valid = (state_q == ST_ISSUE);
  assign move_bus.O_move_dir   = (state_q == ST_ISSUE) ? dir_q : DIR_NONE;
  assign O_move_count          = count_q;
  assign O_busy                = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign O_drop                = drop_q;
  assign O_locked              = (state_q == ST_LOCK);
  assign O_dbg_state           = state_q;

endmodule
